// File: rtl/mul_pkg.sv
// Shared definitions for the iterative multiplier: ALU op codes for the
// RV32M/RV64M multiply group, the control state encoding and a decode helper.
package mul_pkg;

    localparam logic [4:0] ALUC_MUL    = 5'b01001;
    localparam logic [4:0] ALUC_MULH   = 5'b01010;
    localparam logic [4:0] ALUC_MULHSU = 5'b01011;
    localparam logic [4:0] ALUC_MULHU  = 5'b01100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_e;

    // True for the four codes this unit executes.
    function automatic logic is_mul(input logic [4:0] aluc);
        return (aluc == ALUC_MUL)    || (aluc == ALUC_MULH) ||
               (aluc == ALUC_MULHSU) || (aluc == ALUC_MULHU);
    endfunction

endpackage

// File: rtl/mul_iter_unit_if.sv
// Request/result bundle of the iterative multiplier.
// Handshake: a request moves on a rising edge where valid_i && ready_o (and no
// flush); a result moves on a rising edge where valid_o && result_ready_i.
// result_o is only meaningful while valid_o is high. state_o is a debug view
// of the control state.
interface mul_iter_unit_if #(
    parameter int XLEN = 32
);
    import mul_pkg::*;

    logic            valid_i;
    logic [4:0]      aluc_i;
    logic [XLEN-1:0] operand_ra_i;
    logic [XLEN-1:0] operand_rb_i;
    logic            ready_o;
    logic            flush_i;
    logic            valid_o;
    logic            result_ready_i;
    logic [XLEN-1:0] result_o;
    logic            busy_o;
    state_e          state_o;

    // Requester / consumer side.
    modport master (
        output valid_i, aluc_i, operand_ra_i, operand_rb_i, flush_i, result_ready_i,
        input  ready_o, valid_o, result_o, busy_o, state_o
    );

    // Multiplier side.
    modport slave (
        input  valid_i, aluc_i, operand_ra_i, operand_rb_i, flush_i, result_ready_i,
        output ready_o, valid_o, result_o, busy_o, state_o
    );

endinterface

// File: rtl/mul_digit_step.sv
// One radix-2^BPC shift-add step: acc_o = acc_i + (mag_a_i * digit_i) << (BPC*k_i).
// Purely combinational; the caller owns all state.
module mul_digit_step #(
    parameter int XLEN = 32,
    parameter int BPC  = 4,
    parameter int KW   = 4
) (
    input  logic [2*XLEN-1:0] acc_i,
    input  logic [XLEN-1:0]   mag_a_i,
    input  logic [BPC-1:0]    digit_i,
    input  logic [KW-1:0]     k_i,
    output logic [2*XLEN-1:0] acc_o
);

    localparam int PW  = XLEN + BPC;
    localparam int SHW = $clog2(2 * XLEN);

    logic [PW-1:0]     prod;
    logic [SHW-1:0]    shamt;
    logic [2*XLEN-1:0] addend;

    // Partial product of one multiplier digit, aligned to its digit position.
    always_comb begin
        prod   = {{BPC{1'b0}}, mag_a_i} * {{XLEN{1'b0}}, digit_i};
        shamt  = SHW'(k_i) * SHW'(BPC);
        addend = {{(XLEN - BPC){1'b0}}, prod} << shamt;
        acc_o  = acc_i + addend;
    end

endmodule

// File: rtl/mul_iter_unit.sv
// Iterative multiplier for MUL/MULH/MULHSU/MULHU. Operands are reduced to
// magnitudes on accept, the magnitude product is built BPC multiplier bits per
// cycle, and the sign is applied once at the end before the requested half is
// registered onto result_o.
module mul_iter_unit
    import mul_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int BPC  = 4
) (
    input  logic           clk_i,
    input  logic           rst_i,
    mul_iter_unit_if.slave bus
);

    localparam int ITER = XLEN / BPC;
    localparam int CW   = $clog2(ITER) + 1;

    state_e            state_q, state_d;
    logic [4:0]        op_q, op_d;
    logic [XLEN-1:0]   mag_a_q, mag_a_d;
    logic [XLEN-1:0]   b_q, b_d;
    logic              neg_q, neg_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic              a_signed, b_signed;
    logic              neg_a, neg_b;
    logic [XLEN-1:0]   mag_a_in, mag_b_in;
    logic              accept;
    logic              hi_sel;
    logic [2*XLEN-1:0] acc_step;
    logic [2*XLEN-1:0] acc_fix;

    // Request decode: signedness per op, operand magnitudes and accept strobe.
    always_comb begin
        a_signed = (bus.aluc_i == ALUC_MULH) || (bus.aluc_i == ALUC_MULHSU);
        b_signed = (bus.aluc_i == ALUC_MULH);
        neg_a    = a_signed & bus.operand_ra_i[XLEN-1];
        neg_b    = b_signed & bus.operand_rb_i[XLEN-1];
        mag_a_in = neg_a ? (~bus.operand_ra_i + XLEN'(1)) : bus.operand_ra_i;
        mag_b_in = neg_b ? (~bus.operand_rb_i + XLEN'(1)) : bus.operand_rb_i;
        accept   = (state_q == IDLE) && bus.valid_i && !bus.flush_i && is_mul(bus.aluc_i);
    end

    mul_digit_step #(
        .XLEN (XLEN),
        .BPC  (BPC),
        .KW   (CW)
    ) u_step (
        .acc_i   (acc_q),
        .mag_a_i (mag_a_q),
        .digit_i (b_q[BPC-1:0]),
        .k_i     (cnt_q),
        .acc_o   (acc_step)
    );

    // Sign fix-up of the full-width product and selection of the wanted half.
    always_comb begin
        hi_sel  = (op_q != ALUC_MUL);
        acc_fix = neg_q ? (~acc_q + (2*XLEN)'(1)) : acc_q;
    end

    // Next-state logic for control and datapath; flush overrides everything.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        mag_a_d  = mag_a_q;
        b_d      = b_q;
        neg_d    = neg_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = CALC;
                    op_d    = bus.aluc_i;
                    mag_a_d = mag_a_in;
                    b_d     = mag_b_in;
                    neg_d   = neg_a ^ neg_b;
                    acc_d   = '0;
                    cnt_d   = '0;
                end
            end
            CALC: begin
                acc_d = acc_step;
                b_d   = b_q >> BPC;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(ITER - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                acc_d    = acc_fix;
                result_d = hi_sel ? acc_fix[2*XLEN-1:XLEN] : acc_fix[XLEN-1:0];
                state_d  = DONE;
            end
            DONE: begin
                if (bus.result_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (bus.flush_i) begin
            state_d = IDLE;
        end
    end

    // State, operand, accumulator and result registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= IDLE;
            op_q     <= '0;
            mag_a_q  <= '0;
            b_q      <= '0;
            neg_q    <= 1'b0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            mag_a_q  <= mag_a_d;
            b_q      <= b_d;
            neg_q    <= neg_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    // Status outputs decoded from the state register.
    always_comb begin
        bus.ready_o  = (state_q == IDLE);
        bus.valid_o  = (state_q == DONE);
        bus.busy_o   = (state_q != IDLE);
        bus.result_o = result_q;
        bus.state_o  = state_q;
    end

endmodule

// File: tb/tb_mul_iter_unit.sv
// Bench for mul_iter_unit: one 32/4 and one 64/8 instance share the stimulus
// signals; sel64 chooses which instance a request goes to and whose outputs
// are observed.
module tb_mul_iter_unit;
    import mul_pkg::*;

    typedef struct {
        logic [4:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] lit;
        int          hold;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        sel64;
    logic        valid_i;
    logic [4:0]  aluc;
    logic [63:0] ra;
    logic [63:0] rb;
    logic        flush;
    logic        rres;

    int n_assert = 0;
    int n_fail   = 0;
    logic [63:0] exp_q[$];

    mul_iter_unit_if #(.XLEN(32)) bus32 ();
    mul_iter_unit_if #(.XLEN(64)) bus64 ();

    assign bus32.valid_i        = valid_i & ~sel64;
    assign bus32.aluc_i         = aluc;
    assign bus32.operand_ra_i   = ra[31:0];
    assign bus32.operand_rb_i   = rb[31:0];
    assign bus32.flush_i        = flush;
    assign bus32.result_ready_i = rres;

    assign bus64.valid_i        = valid_i & sel64;
    assign bus64.aluc_i         = aluc;
    assign bus64.operand_ra_i   = ra;
    assign bus64.operand_rb_i   = rb;
    assign bus64.flush_i        = flush;
    assign bus64.result_ready_i = rres;

    wire        d_ready  = sel64 ? bus64.ready_o : bus32.ready_o;
    wire        d_valid  = sel64 ? bus64.valid_o : bus32.valid_o;
    wire        d_busy   = sel64 ? bus64.busy_o  : bus32.busy_o;
    wire [63:0] d_result = sel64 ? bus64.result_o : {32'b0, bus32.result_o};

    mul_iter_unit #(.XLEN(32), .BPC(4)) dut32 (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus32.slave)
    );

    mul_iter_unit #(.XLEN(64), .BPC(8)) dut64 (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus64.slave)
    );

    // Clock and watchdog.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: sign/zero-extend to 128 bits, multiply, pick the half.
    function automatic logic [63:0] model(input logic [4:0] op, input logic [63:0] a,
                                          input logic [63:0] b, input logic w64);
        int           xl;
        logic [63:0]  mask;
        logic [127:0] ea, eb, p, ones, hi;
        xl   = w64 ? 64 : 32;
        mask = w64 ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        ones = '1;
        ea   = {64'b0, a & mask};
        eb   = {64'b0, b & mask};
        if ((op == ALUC_MULH || op == ALUC_MULHSU) && ea[xl-1]) ea = ea | (ones << xl);
        if ((op == ALUC_MULH) && eb[xl-1]) eb = eb | (ones << xl);
        p  = ea * eb;
        hi = p >> xl;
        if (op == ALUC_MUL) return p[63:0] & mask;
        return hi[63:0] & mask;
    endfunction

    // Scoreboard: every cycle with valid_o high is checked against the model
    // queue; results must hold while the consumer stalls.
    logic        hold_v = 1'b0;
    logic [63:0] hold_r = '0;
    always @(negedge clk) begin
        #1;
        if (rst_n) begin
            if (d_valid) begin
                if (exp_q.size() == 0) begin
                    check("valid_without_request", 64'(d_valid), 64'(0));
                end else begin
                    check("result_vs_model", d_result, exp_q[0]);
                end
                if (hold_v) check("result_stable", d_result, hold_r);
                hold_v = !rres;
                hold_r = d_result;
                if (rres && exp_q.size() > 0) void'(exp_q.pop_front());
            end else begin
                hold_v = 1'b0;
            end
        end
    end

    // One full transaction with latency, ready and literal checks.
    task automatic run(input vec_t v);
        int   cyc;
        int   iter_p1;
        logic got;
        iter_p1 = (sel64 ? 64 / 8 : 32 / 4) + 1;
        @(negedge clk);
        check("ready_before_accept", 64'(d_ready), 64'(1));
        valid_i = 1'b1;
        aluc    = v.op;
        ra      = v.a;
        rb      = v.b;
        rres    = (v.hold == 0);
        exp_q.push_back(model(v.op, v.a, v.b, sel64));
        @(posedge clk);
        cyc = 0;
        got = 1'b0;
        while (!got && cyc <= 40) begin
            @(negedge clk);
            valid_i = 1'b0;
            if (d_valid) begin
                got = 1'b1;
            end else begin
                check("ready_low_while_busy", 64'(d_ready), 64'(0));
                @(posedge clk);
                cyc++;
            end
        end
        if (!got) begin
            check("valid_timeout", 64'(d_valid), 64'(1));
            return;
        end
        check("latency", 64'(cyc), 64'(iter_p1));
        check("result_literal", d_result, v.lit);
        if (v.hold > 0) begin
            repeat (v.hold) begin
                @(negedge clk);
                check("valid_held", 64'(d_valid), 64'(1));
            end
            rres = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        check("ready_after_take", 64'(d_ready), 64'(1));
        check("valid_after_take", 64'(d_valid), 64'(0));
        rres = 1'b0;
    endtask

    task automatic add(inout vec_t q[$], input logic [4:0] op, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] lit, input int hold);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.lit = lit; v.hold = hold;
        q.push_back(v);
    endtask

    vec_t v32[$];
    vec_t v64[$];

    initial begin
        rst_n = 1'b0; sel64 = 1'b0; valid_i = 1'b0; aluc = '0;
        ra = '0; rb = '0; flush = 1'b0; rres = 1'b0;

        add(v32, ALUC_MUL,    64'd7,          64'd6,          64'h2A,       0);
        add(v32, ALUC_MULH,   64'hFFFFFFFF,   64'hFFFFFFFF,   64'h0,        0);
        add(v32, ALUC_MUL,    64'hFFFFFFFF,   64'hFFFFFFFF,   64'h1,        0);
        add(v32, ALUC_MULHSU, 64'hFFFFFFFF,   64'hFFFFFFFF,   64'hFFFFFFFF, 0);
        add(v32, ALUC_MULHU,  64'hFFFFFFFF,   64'hFFFFFFFF,   64'hFFFFFFFE, 0);
        add(v32, ALUC_MULH,   64'h80000000,   64'h80000000,   64'h40000000, 0);
        add(v32, ALUC_MULH,   64'h80000000,   64'h1,          64'hFFFFFFFF, 0);
        add(v32, ALUC_MUL,    64'hFFFFFFFE,   64'd3,          64'hFFFFFFFA, 0);
        add(v32, ALUC_MULH,   64'hFFFFFFFE,   64'd3,          64'hFFFFFFFF, 0);
        add(v32, ALUC_MULHU,  64'h00010000,   64'h00010000,   64'h1,        5);

        add(v64, ALUC_MUL,    64'd7, 64'd6, 64'h2A, 0);
        add(v64, ALUC_MULH,   '1, '1, 64'h0, 0);
        add(v64, ALUC_MUL,    '1, '1, 64'h1, 0);
        add(v64, ALUC_MULHSU, '1, '1, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        add(v64, ALUC_MULHU,  '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 0);
        add(v64, ALUC_MULH,   64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
            64'h4000_0000_0000_0000, 0);
        add(v64, ALUC_MULH,   64'h8000_0000_0000_0000, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        add(v64, ALUC_MULHU,  64'h0000_0001_0000_0000, 64'h0000_0001_0000_0000, 64'h1, 5);

        // Reset values on both instances.
        #12;
        check("rst_ready32",  64'(bus32.ready_o),  64'(1));
        check("rst_valid32",  64'(bus32.valid_o),  64'(0));
        check("rst_busy32",   64'(bus32.busy_o),   64'(0));
        check("rst_result32", 64'(bus32.result_o), 64'(0));
        check("rst_ready64",  64'(bus64.ready_o),  64'(1));
        check("rst_result64", bus64.result_o,      64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        foreach (v32[i]) run(v32[i]);

        // Flush on the third CALC cycle: nothing is produced.
        @(negedge clk);
        valid_i = 1'b1; aluc = ALUC_MUL; ra = 64'd100; rb = 64'd200; rres = 1'b1;
        @(posedge clk);
        @(negedge clk); valid_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk); flush = 1'b1;
        @(posedge clk);
        @(negedge clk); flush = 1'b0;
        check("flush_ready", 64'(d_ready), 64'(1));
        check("flush_valid", 64'(d_valid), 64'(0));
        check("flush_busy",  64'(d_busy),  64'(0));
        repeat (12) begin
            @(negedge clk);
            check("flush_no_valid", 64'(d_valid), 64'(0));
        end
        rres = 1'b0;
        begin
            vec_t v;
            v.op = ALUC_MUL; v.a = 64'd3; v.b = 64'd5; v.lit = 64'd15; v.hold = 0;
            run(v);
        end

        // Flush together with a request: nothing accepted.
        @(negedge clk);
        valid_i = 1'b1; flush = 1'b1; aluc = ALUC_MUL; ra = 64'd9; rb = 64'd9;
        @(posedge clk);
        @(negedge clk); valid_i = 1'b0; flush = 1'b0;
        check("flush_wins_busy",  64'(d_busy),  64'(0));
        check("flush_wins_ready", 64'(d_ready), 64'(1));

        // Non-multiply code is ignored.
        @(negedge clk);
        valid_i = 1'b1; aluc = 5'b00000; ra = 64'd2; rb = 64'd2;
        check("nonmul_ready", 64'(d_ready), 64'(1));
        @(posedge clk);
        @(negedge clk); valid_i = 1'b0;
        check("nonmul_busy",  64'(d_busy),  64'(0));

        // Asynchronous reset in the middle of CALC.
        @(negedge clk);
        valid_i = 1'b1; aluc = ALUC_MUL; ra = 64'h1234; rb = 64'h10;
        @(posedge clk);
        @(negedge clk); valid_i = 1'b0;
        @(negedge clk);
        check("calc_busy", 64'(d_busy), 64'(1));
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_ready",  64'(d_ready),  64'(1));
        check("async_rst_valid",  64'(d_valid),  64'(0));
        check("async_rst_busy",   64'(d_busy),   64'(0));
        check("async_rst_result", d_result,      64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Same arithmetic on the 64-bit, 8-bits-per-cycle instance.
        sel64 = 1'b1;
        foreach (v64[i]) run(v64[i]);

        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
